// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking for a 5x5 crossbar.
// Latency: requests sampled at edge N produce grants/grant_ports after that edge (1 cycle).
// Backpressure: out_ready low withholds the grant; a locked output keeps its owner until the tail.
module switch_allocator #(
    parameter int IN_PORTS      = 5,
    parameter int OUT_PORTS     = 5,
    parameter int OUT_PORT_BITS = 3,
    parameter int IN_PORT_BITS  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IN_PORTS-1:0]               req_valid,
    input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
    input  logic [IN_PORTS-1:0]               req_tail,
    input  logic [OUT_PORTS-1:0]              out_ready,
    output logic [IN_PORTS-1:0]               grants,
    output logic [IN_PORTS*OUT_PORT_BITS-1:0] grant_ports,
    output logic [OUT_PORTS-1:0]              out_busy,
    output logic [IN_PORTS-1:0]               bad_req
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q  [OUT_PORTS];
    logic [IN_PORT_BITS-1:0] rr_ptr_q [OUT_PORTS];
    logic [IN_PORT_BITS-1:0] owner_q  [OUT_PORTS];

    logic [IN_PORTS-1:0]               cand [OUT_PORTS];
    logic [OUT_PORTS-1:0]              win_vld;
    logic [IN_PORT_BITS-1:0]           win_idx [OUT_PORTS];
    logic [IN_PORTS-1:0]               gnt_nxt;
    logic [IN_PORTS-1:0]               bad_nxt;
    logic [IN_PORTS*OUT_PORT_BITS-1:0] gp_nxt;

    always_comb begin
        for (int o = 0; o < OUT_PORTS; o++) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                cand[o][i] = req_valid[i] &&
                    (req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS] == OUT_PORT_BITS'(o));
            end
        end
    end

    // Scan downward so the entry closest to rr_ptr is the last one written and wins.
    always_comb begin
        int                      idx;
        logic [IN_PORT_BITS-1:0] idx_b;
        idx   = 0;
        idx_b = '0;
        for (int o = 0; o < OUT_PORTS; o++) begin
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            if (out_ready[o]) begin
                if (state_q[o] == LOCKED) begin
                    if (cand[o][owner_q[o]]) begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = owner_q[o];
                    end
                end else begin
                    for (int k = IN_PORTS - 1; k >= 0; k--) begin
                        idx   = (int'(rr_ptr_q[o]) + k) % IN_PORTS;
                        idx_b = IN_PORT_BITS'(idx);
                        if (cand[o][idx_b]) begin
                            win_vld[o] = 1'b1;
                            win_idx[o] = idx_b;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < IN_PORTS; i++) begin
            gnt_nxt[i] = 1'b0;
            for (int o = 0; o < OUT_PORTS; o++) begin
                if (win_vld[o] && (win_idx[o] == IN_PORT_BITS'(i))) begin
                    gnt_nxt[i] = 1'b1;
                end
            end
            gp_nxt[i*OUT_PORT_BITS +: OUT_PORT_BITS] =
                gnt_nxt[i] ? req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS] : '0;
            bad_nxt[i] = req_valid[i] &&
                (int'(req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS]) >= OUT_PORTS);
        end
    end

    always_comb begin
        for (int o = 0; o < OUT_PORTS; o++) begin
            out_busy[o] = (state_q[o] == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grants      <= '0;
            grant_ports <= '0;
            bad_req     <= '0;
            for (int o = 0; o < OUT_PORTS; o++) begin
                state_q[o]  <= IDLE;
                rr_ptr_q[o] <= '0;
                owner_q[o]  <= '0;
            end
        end else begin
            grants      <= gnt_nxt;
            grant_ports <= gp_nxt;
            bad_req     <= bad_nxt;
            for (int o = 0; o < OUT_PORTS; o++) begin
                if (win_vld[o]) begin
                    // Pointer only moves when a packet completes, so it stays frozen while locked.
                    if (req_tail[win_idx[o]]) begin
                        state_q[o]  <= IDLE;
                        rr_ptr_q[o] <= (win_idx[o] == IN_PORT_BITS'(IN_PORTS - 1)) ?
                                       '0 : win_idx[o] + IN_PORT_BITS'(1);
                    end else begin
                        state_q[o] <= LOCKED;
                        owner_q[o] <= win_idx[o];
                    end
                end
            end
        end
    end

endmodule
